// File: rtl/toaplan_v1_pkg.sv
// Shared types for the Toaplan v1 core: 68K/Z80 work-RAM arbiter states,
// port ownership and the shared-RAM address width.
package toaplan_v1_pkg;

   localparam int SHARED_RAM_AW = 11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_M68K = 1'b0,
      OWN_Z80  = 1'b1
   } owner_t;

   // Round-robin on a tie: the port that did not win last time goes first.
   function automatic owner_t pick_grant(input logic m68k_pending,
                                         input logic z80_pending,
                                         input owner_t last_grant);
      if (m68k_pending && z80_pending)
         return (last_grant == OWN_M68K) ? OWN_Z80 : OWN_M68K;
      else if (z80_pending)
         return OWN_Z80;
      else
         return OWN_M68K;
   endfunction

endpackage

// File: rtl/shared_ram_arbiter_if.sv
// CPU-side and BRAM-side signals of the shared work-RAM arbiter.
// slave = the arbiter itself, master = bus glue / BRAM around it.
interface shared_ram_arbiter_if #(
   parameter int ADDR_W = toaplan_v1_pkg::SHARED_RAM_AW
);
   logic              m68k_req;
   logic              m68k_we;
   logic [ADDR_W-1:0] m68k_addr;
   logic [7:0]        m68k_din;
   logic [7:0]        m68k_dout;
   logic              m68k_ack;

   logic              z80_req;
   logic              z80_we;
   logic [ADDR_W-1:0] z80_addr;
   logic [7:0]        z80_din;
   logic [7:0]        z80_dout;
   logic              z80_wait_n;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [7:0]        ram_wdata;
   logic [7:0]        ram_rdata;

   modport slave (
      input  m68k_req, m68k_we, m68k_addr, m68k_din,
      output m68k_dout, m68k_ack,
      input  z80_req, z80_we, z80_addr, z80_din,
      output z80_dout, z80_wait_n,
      output ram_addr, ram_we, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output m68k_req, m68k_we, m68k_addr, m68k_din,
      input  m68k_dout, m68k_ack,
      output z80_req, z80_we, z80_addr, z80_din,
      input  z80_dout, z80_wait_n,
      input  ram_addr, ram_we, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/shared_ram_port_tracker.sv
// Per-CPU request tracker: a completed access is remembered until the CPU
// drops its request, so a held request never gets a second access.
module shared_ram_port_tracker (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic req,
   input  logic done,
   output logic pending,
   output logic served
);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         served <= 1'b0;
      else if (!req)
         served <= 1'b0;
      else if (done)
         served <= 1'b1;
   end

   assign pending = req & ~served;

endmodule

// File: rtl/shared_ram_arbiter.sv
// Time-shares one synchronous BRAM port between the 68K and the Z80;
// one-cycle ack to the 68K DTACK logic, combinational WAIT to the Z80.
module shared_ram_arbiter
   import toaplan_v1_pkg::*;
#(
   parameter int ADDR_W      = SHARED_RAM_AW,
   parameter int RAM_LATENCY = 1
) (
   input  logic                 clk_sys,
   input  logic                 reset_n,
   shared_ram_arbiter_if.slave  bus
);

   localparam logic [1:0] LAT = 2'(RAM_LATENCY);

   arb_state_t        state;
   owner_t            owner;
   owner_t            last_grant;
   owner_t            grant_sel;
   logic [1:0]        cnt;
   logic              acc_we;

   logic [ADDR_W-1:0] ram_addr_q;
   logic [7:0]        ram_wdata_q;
   logic              ram_we_q;
   logic [7:0]        m68k_dout_q;
   logic [7:0]        z80_dout_q;
   logic              m68k_ack_q;

   logic              m68k_pending, m68k_served, m68k_done;
   logic              z80_pending,  z80_served,  z80_done;

   // A withdrawn request still lets the access finish, but earns no completion.
   assign m68k_done = (state == DONE) && (owner == OWN_M68K) && bus.m68k_req && !m68k_served;
   assign z80_done  = (state == DONE) && (owner == OWN_Z80)  && bus.z80_req  && !z80_served;

   assign grant_sel = pick_grant(m68k_pending, z80_pending, last_grant);

   shared_ram_port_tracker u_m68k_trk (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .req     (bus.m68k_req),
      .done    (m68k_done),
      .pending (m68k_pending),
      .served  (m68k_served)
   );

   shared_ram_port_tracker u_z80_trk (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .req     (bus.z80_req),
      .done    (z80_done),
      .pending (z80_pending),
      .served  (z80_served)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         owner       <= OWN_M68K;
         last_grant  <= OWN_Z80;
         cnt         <= 2'd0;
         acc_we      <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= 8'h00;
         ram_we_q    <= 1'b0;
         m68k_dout_q <= 8'h00;
         z80_dout_q  <= 8'h00;
         m68k_ack_q  <= 1'b0;
      end else begin
         ram_we_q   <= 1'b0;
         m68k_ack_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (m68k_pending || z80_pending) begin
                  owner      <= grant_sel;
                  last_grant <= grant_sel;
                  cnt        <= LAT;
                  state      <= ACCESS;
                  if (grant_sel == OWN_M68K) begin
                     ram_addr_q  <= bus.m68k_addr;
                     ram_wdata_q <= bus.m68k_din;
                     ram_we_q    <= bus.m68k_we;
                     acc_we      <= bus.m68k_we;
                  end else begin
                     ram_addr_q  <= bus.z80_addr;
                     ram_wdata_q <= bus.z80_din;
                     ram_we_q    <= bus.z80_we;
                     acc_we      <= bus.z80_we;
                  end
               end
            end
            // Wait out the BRAM read latency before sampling ram_rdata.
            ACCESS: begin
               cnt <= cnt - 2'd1;
               if (cnt == 2'd1)
                  state <= DONE;
            end
            DONE: begin
               if (m68k_done) begin
                  m68k_ack_q <= 1'b1;
                  if (!acc_we)
                     m68k_dout_q <= bus.ram_rdata;
               end
               if (z80_done && !acc_we)
                  z80_dout_q <= bus.ram_rdata;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_wdata  = ram_wdata_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.m68k_dout  = m68k_dout_q;
   assign bus.m68k_ack   = m68k_ack_q;
   assign bus.z80_dout   = z80_dout_q;
   assign bus.z80_wait_n = ~(bus.z80_req & ~z80_served);

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Scoreboard bench for shared_ram_arbiter: one instance at RAM_LATENCY=1,
// one at RAM_LATENCY=3, each with its own BRAM model.
module tb_shared_ram_arbiter;
   import toaplan_v1_pkg::*;

   localparam int AW = SHARED_RAM_AW;

   typedef struct packed {
      logic       rd;
      logic [7:0] data;
   } exp_t;

   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk_sys = ~clk_sys;

   shared_ram_arbiter_if #(.ADDR_W(AW)) bus1 ();
   shared_ram_arbiter_if #(.ADDR_W(AW)) bus3 ();

   shared_ram_arbiter #(.ADDR_W(AW), .RAM_LATENCY(1)) dut1 (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus1.slave)
   );

   shared_ram_arbiter #(.ADDR_W(AW), .RAM_LATENCY(3)) dut3 (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus3.slave)
   );

   // BRAM models
   logic [7:0] mem1 [2048];
   logic [7:0] mem3 [2048];
   logic [7:0] rd3_a, rd3_b;

   always @(posedge clk_sys) begin
      if (bus1.ram_we) mem1[bus1.ram_addr] <= bus1.ram_wdata;
      bus1.ram_rdata <= mem1[bus1.ram_addr];
   end

   always @(posedge clk_sys) begin
      if (bus3.ram_we) mem3[bus3.ram_addr] <= bus3.ram_wdata;
      rd3_a          <= mem3[bus3.ram_addr];
      rd3_b          <= rd3_a;
      bus3.ram_rdata <= rd3_b;
   end

   // Scoreboard state
   exp_t       m1_q[$], z1_q[$], m3_q[$], z3_q[$];
   exp_t       e1, e3;
   logic [7:0] ref1 [logic [10:0]];
   logic [7:0] z1_last = 8'h00;
   logic       z1_wprev = 1'b1, z3_wprev = 1'b1;
   int         we1_cnt = 0, acc1_cnt = 0, ack1_cnt = 0;
   int         n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(negedge clk_sys) begin
      if (reset_n && bus1.m68k_ack) begin
         ack1_cnt++;
         if (m1_q.size() == 0) chk("m68k_spurious_ack", 1, 0);
         else begin
            e1 = m1_q.pop_front();
            if (e1.rd) chk("m68k_dout", bus1.m68k_dout, e1.data);
         end
      end
      if (reset_n && !z1_wprev && bus1.z80_wait_n && bus1.z80_req) begin
         if (z1_q.size() == 0) chk("z80_spurious_done", 1, 0);
         else begin
            e1 = z1_q.pop_front();
            if (e1.rd) begin
               chk("z80_dout", bus1.z80_dout, e1.data);
               z1_last = e1.data;
            end
         end
      end
      z1_wprev = bus1.z80_wait_n;
      if (bus1.ram_we) we1_cnt++;
      if (dut1.state == ACCESS) acc1_cnt++;
   end

   always @(negedge clk_sys) begin
      if (reset_n && bus3.m68k_ack) begin
         if (m3_q.size() == 0) chk("m68k_l3_spurious_ack", 1, 0);
         else begin
            e3 = m3_q.pop_front();
            if (e3.rd) chk("m68k_l3_dout", bus3.m68k_dout, e3.data);
         end
      end
      if (reset_n && !z3_wprev && bus3.z80_wait_n && bus3.z80_req) begin
         if (z3_q.size() == 0) chk("z80_l3_spurious_done", 1, 0);
         else begin
            e3 = z3_q.pop_front();
            if (e3.rd) chk("z80_l3_dout", bus3.z80_dout, e3.data);
         end
      end
      z3_wprev = bus3.z80_wait_n;
   end

   // Stimulus helpers (instance 1 drive, either instance wait)
   task automatic m_start(input logic we, input logic [10:0] a, input logic [7:0] d);
      exp_t e;
      @(negedge clk_sys); #1;
      bus1.m68k_we = we; bus1.m68k_addr = a; bus1.m68k_din = d; bus1.m68k_req = 1'b1;
      if (we) ref1[a] = d;
      e.rd = !we; e.data = we ? 8'h00 : ref1[a];
      m1_q.push_back(e);
   endtask

   task automatic z_start(input logic we, input logic [10:0] a, input logic [7:0] d);
      exp_t e;
      @(negedge clk_sys); #1;
      bus1.z80_we = we; bus1.z80_addr = a; bus1.z80_din = d; bus1.z80_req = 1'b1;
      if (we) ref1[a] = d;
      e.rd = !we; e.data = we ? 8'h00 : ref1[a];
      z1_q.push_back(e);
   endtask

   task automatic m_wait(input int inst, output int lat);
      logic ack;
      lat = 0; ack = 1'b0;
      while (!ack && lat < 40) begin
         @(posedge clk_sys); lat++;
         @(negedge clk_sys);
         ack = (inst == 1) ? bus1.m68k_ack : bus3.m68k_ack;
      end
      if (!ack) chk("m68k_ack_timeout", 0, 1);
   endtask

   task automatic z_wait(input int inst, input int lat0, output int lat);
      logic rdy;
      lat = lat0; rdy = 1'b0;
      while (!rdy && lat < 40) begin
         @(posedge clk_sys); lat++;
         @(negedge clk_sys);
         rdy = (inst == 1) ? bus1.z80_wait_n : bus3.z80_wait_n;
      end
      if (!rdy) chk("z80_wait_timeout", 0, 1);
   endtask

   int lm, lz, base_we, base_acc, base_ack;

   initial begin
      bus1.m68k_req = 0; bus1.m68k_we = 0; bus1.m68k_addr = '0; bus1.m68k_din = 0;
      bus1.z80_req  = 0; bus1.z80_we  = 0; bus1.z80_addr  = '0; bus1.z80_din  = 0;
      bus3.m68k_req = 0; bus3.m68k_we = 0; bus3.m68k_addr = '0; bus3.m68k_din = 0;
      bus3.z80_req  = 0; bus3.z80_we  = 0; bus3.z80_addr  = '0; bus3.z80_din  = 0;

      // Power-on reset
      repeat (3) @(negedge clk_sys);
      chk("rst_ack", bus1.m68k_ack, 0);
      chk("rst_ram_we", bus1.ram_we, 0);
      chk("rst_wait_n", bus1.z80_wait_n, 1);
      chk("rst_ram_addr", bus1.ram_addr, 0);
      chk("rst_dout", {bus1.m68k_dout, bus1.z80_dout}, 0);
      chk("rst_state", 32'(dut1.state), 32'(IDLE));
      #1 reset_n = 1'b1;

      // 68K write 0x123 <= 0x5A, then Z80 reads it back
      base_we = we1_cnt;
      m_start(1'b1, 11'h123, 8'h5A);
      m_wait(1, lm);
      #1 bus1.m68k_req = 1'b0;
      chk("m68k_wr_lat", lm, 3);
      chk("m68k_wr_we_pulses", we1_cnt - base_we, 1);
      z_start(1'b0, 11'h123, 8'h00);
      z_wait(1, 0, lz);
      #1 bus1.z80_req = 1'b0;
      chk("z80_rd_lat", lz, 3);

      // Asynchronous reset in the middle of a 68K read
      m_start(1'b0, 11'h123, 8'h00);
      @(posedge clk_sys); @(negedge clk_sys);
      chk("mid_pre_state", 32'(dut1.state), 32'(ACCESS));
      #1 reset_n = 1'b0;
      #1;
      chk("mid_ack", bus1.m68k_ack, 0);
      chk("mid_ram_we", bus1.ram_we, 0);
      chk("mid_wait_n", bus1.z80_wait_n, 1);
      chk("mid_ram_addr", bus1.ram_addr, 0);
      chk("mid_ram_wdata", bus1.ram_wdata, 0);
      chk("mid_z80_dout", bus1.z80_dout, 0);
      chk("mid_m68k_dout", bus1.m68k_dout, 0);
      chk("mid_state", 32'(dut1.state), 32'(IDLE));
      m1_q.delete();
      bus1.m68k_req = 1'b0;
      z1_last = 8'h00;
      @(negedge clk_sys); #1 reset_n = 1'b1;

      // First tie after reset: 68K first, Z80 right after
      fork
         begin m_start(1'b1, 11'h010, 8'h11); m_wait(1, lm); #1 bus1.m68k_req = 1'b0; end
         begin z_start(1'b0, 11'h123, 8'h00); z_wait(1, 0, lz); #1 bus1.z80_req = 1'b0; end
      join
      chk("tie1_m68k_lat", lm, 3);
      chk("tie1_z80_lat", lz, 6);

      // Lone 68K access leaves last_grant = 68K, so the next tie goes to the Z80
      m_start(1'b1, 11'h020, 8'h22);
      m_wait(1, lm);
      #1 bus1.m68k_req = 1'b0;
      chk("solo_m68k_lat", lm, 3);
      fork
         begin m_start(1'b0, 11'h010, 8'h00); m_wait(1, lm); #1 bus1.m68k_req = 1'b0; end
         begin z_start(1'b1, 11'h030, 8'h33); z_wait(1, 0, lz); #1 bus1.z80_req = 1'b0; end
      join
      chk("tie2_z80_lat", lz, 3);
      chk("tie2_m68k_lat", lm, 6);

      // 68K holds req after ack: one access only until req is dropped
      base_acc = acc1_cnt; base_ack = ack1_cnt;
      m_start(1'b0, 11'h020, 8'h00);
      m_wait(1, lm);
      chk("hold_lat", lm, 3);
      repeat (8) @(negedge clk_sys);
      #1;
      chk("hold_acks", ack1_cnt - base_ack, 1);
      chk("hold_accesses", acc1_cnt - base_acc, 1);
      bus1.m68k_req = 1'b0;
      m_start(1'b0, 11'h030, 8'h00);
      m_wait(1, lm);
      #1 bus1.m68k_req = 1'b0;
      chk("rereq_lat", lm, 3);
      chk("rereq_acks", ack1_cnt - base_ack, 2);

      // Z80 write withdrawn during ACCESS still commits, without completion
      base_we = we1_cnt;
      @(negedge clk_sys); #1;
      bus1.z80_we = 1'b1; bus1.z80_addr = 11'h7FF; bus1.z80_din = 8'hA5; bus1.z80_req = 1'b1;
      ref1[11'h7FF] = 8'hA5;
      @(posedge clk_sys); @(negedge clk_sys); #1;
      bus1.z80_req = 1'b0;
      repeat (4) @(negedge clk_sys);
      chk("wd_we_pulses", we1_cnt - base_we, 1);
      chk("wd_z80_dout", bus1.z80_dout, z1_last);
      chk("wd_wait_n", bus1.z80_wait_n, 1);
      m_start(1'b0, 11'h7FF, 8'h00);
      m_wait(1, lm);
      #1 bus1.m68k_req = 1'b0;
      chk("wd_readback_lat", lm, 3);

      // RAM_LATENCY = 3 instance
      @(negedge clk_sys); #1;
      bus3.m68k_we = 1'b1; bus3.m68k_addr = 11'h055; bus3.m68k_din = 8'h3C; bus3.m68k_req = 1'b1;
      m3_q.push_back(exp_t'{rd: 1'b0, data: 8'h00});
      m_wait(3, lm);
      #1 bus3.m68k_req = 1'b0;
      chk("l3_wr_lat", lm, 5);
      @(negedge clk_sys); #1;
      bus3.z80_we = 1'b0; bus3.z80_addr = 11'h055; bus3.z80_req = 1'b1;
      z3_q.push_back(exp_t'{rd: 1'b1, data: 8'h3C});
      @(posedge clk_sys); @(negedge clk_sys); #1;
      bus3.m68k_we = 1'b0; bus3.m68k_addr = 11'h055; bus3.m68k_req = 1'b1;
      m3_q.push_back(exp_t'{rd: 1'b1, data: 8'h3C});
      fork
         begin z_wait(3, 1, lz); #1 bus3.z80_req = 1'b0; end
         begin m_wait(3, lm); #1 bus3.m68k_req = 1'b0; end
      join
      chk("l3_z80_lat", lz, 5);
      chk("l3_m68k_lat", lm, 9);

      repeat (4) @(negedge clk_sys);
      chk("sb_m68k_empty", m1_q.size(), 0);
      chk("sb_z80_empty", z1_q.size(), 0);
      chk("sb_l3_empty", m3_q.size() + z3_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/shared_ram_arbiter.md
Name: shared_ram_arbiter

Overview:
- Single-port arbiter and sequencer for the 2 KB 68K/Z80 shared work RAM, which the address decoder selects through shared_ram_cs (68K side) and through the Z80 memory window.
- Time-shares one synchronous BRAM port between the two CPUs.
- Returns a one-cycle ack to the 68K DTACK logic and holds Z80 WAIT low until the Z80 access completes.
- Sits between the chip-select/bus glue and the BRAM instance in the Toaplan v1 core top.

Parameters:
- ADDR_W, 11, RAM address width (2048 x 8).
- RAM_LATENCY, 1, clk_sys cycles from ram_addr registered to ram_rdata valid; legal range 1..3.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m68k_req  in  1  level; shared_ram_cs qualified by bus strobe; held until m68k_ack
- m68k_we  in  1  1 = write
- m68k_addr  in  ADDR_W  byte index (68K A11..A1)
- m68k_din  in  8  write data (D7..D0)
- m68k_dout  out  8  read data, valid in the m68k_ack cycle, held afterwards
- m68k_ack  out  1  one-cycle completion pulse
- z80_req  in  1  level; MREQ_n low and Z80 address in shared window
- z80_we  in  1  1 = write
- z80_addr  in  ADDR_W  Z80 A10..A0
- z80_din  in  8  write data
- z80_dout  out  8  read data, valid when z80_wait_n returns high, held afterwards
- z80_wait_n  out  1  low while a Z80 access is pending
- ram_addr  out  ADDR_W  BRAM address
- ram_we  out  1  BRAM write strobe
- ram_wdata  out  8  BRAM write data
- ram_rdata  in  8  BRAM read data

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE.
  - ram_addr, ram_wdata, m68k_dout and z80_dout = 0.
  - ram_we and m68k_ack = 0.
  - last_grant = Z80, so the 68K wins the first tie.
  - Both served flags = 0; z80_wait_n = 1.
- Per-port tracking:
  - pending = req & ~served.
  - served sets in that port's completion cycle and clears on the first cycle req is sampled low.
  - A port that holds req after completion gets no second access.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE:
    - If any port is pending, grant it. On a tie, grant the port that is not last_grant.
    - Register ram_addr, ram_wdata and ram_we (= requester we) from the granted port.
    - Record the owner, set last_grant = owner, load cnt = RAM_LATENCY, go to ACCESS.
  - ACCESS:
    - ram_we deasserts after exactly one cycle (registered 0).
    - cnt decrements each cycle; go to DONE when cnt reaches 1.
  - DONE:
    - If the owner's req is still high:
      - capture ram_rdata into the owner's dout (reads only; writes leave dout unchanged);
      - set the owner's served flag;
      - m68k_ack pulses for one cycle if the owner is the 68K.
    - Go to IDLE. A new grant is possible on the next edge.
- Latency:
  - Grant edge at cycle G; DONE occupies cycle G+RAM_LATENCY+1.
  - With no contention, from the req-sampled edge to ack is RAM_LATENCY+2 cycles.
- z80_wait_n = ~(z80_req & ~z80_served). This is combinational from z80_req so WAIT is seen in the same T-state.
- Request withdrawn while owning the port:
  - The access still completes and any write has already been committed.
  - No ack, no dout update, served stays 0.
- Requests and inputs:
  - Inputs are sampled only at the grant edge.
  - Address or data changes after grant are ignored.
  - Requests arriving during ACCESS/DONE wait in pending.
- Fairness: worst-case wait for any port is one full foreign access, RAM_LATENCY+2 cycles.
- Reset mid-access: abort immediately to reset values, with no ack. A write already strobed stays in RAM.

Decomposition:
- Shared package toaplan_v1_pkg adds:
  - the arb_state_t enum (IDLE, ACCESS, DONE);
  - the owner_t enum (OWN_M68K, OWN_Z80);
  - SHARED_RAM_AW = 11.
- One sub-module, shared_ram_port_tracker:
  - one instance per port;
  - inputs: req and a done strobe;
  - outputs: the pending and served flags.

Test Plan:
- Reset: assert reset_n = 0 mid-simulation -> m68k_ack = 0, ram_we = 0, z80_wait_n = 1, all data outputs = 0, state IDLE, asynchronously with no clock edge needed.
- 68K write then Z80 read:
  - 68K write addr 0x123, din 0x5A -> single ram_we pulse, m68k_ack 3 cycles after req sampled (RAM_LATENCY = 1).
  - Z80 read 0x123 -> z80_wait_n low 3 cycles, z80_dout = 0x5A.
- Tie after reset:
  - Both req rise on the same edge -> 68K granted first, Z80 granted on the cycle after the 68K DONE.
  - Second tie -> Z80 first.
- 68K holds req after ack -> exactly one ram access; no second ack until req low for at least 1 cycle and then high again.
- Z80 write 0xA5 to 0x7FF, z80_req dropped in the ACCESS cycle -> ram_we still pulsed, z80_dout unchanged, a later 68K read of 0x7FF returns 0xA5.
- RAM_LATENCY = 3, Z80 read with 68K req arriving one cycle after the Z80 grant -> Z80 completes in 5 cycles; 68K granted on the next edge, ack 5 cycles later.
